// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

  localparam int INSTR_W    = 32;
  localparam int OPC_MSB    = 31;
  localparam int OPC_LSB    = 26;
  localparam int PC_STEP    = 4;
  // Width of the pc field carried through the instruction buffer; the
  // fetch unit's ADDR_W must not exceed it.
  localparam int MAX_ADDR_W = 32;

  typedef enum logic [1:0] {
    F_REQ  = 2'd0,
    F_WAIT = 2'd1,
    F_DROP = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [INSTR_W-1:0]    instr;
    logic [MAX_ADDR_W-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer between memory response and decode: storage and
// pointers only. Exposes the head entry and the one behind it so the owner
// can compute the next head ahead of the clock edge.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push_i,
  input  logic               pop_i,
  input  logic               flush_i,
  input  fetch_entry_t       wdata_i,
  output fetch_entry_t       head_o,
  output fetch_entry_t       next_o,
  output logic [CNT_W-1:0]   count_o
);

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Pointer/occupancy next state; flush empties the buffer and beats push/pop
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
    end
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage (data only, no reset needed)
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign next_o  = mem_q[rd_ptr_q + PTR_W'(1)];
  assign count_o = count_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: owns the PC, issues one outstanding word read at a
// time, buffers responses and hands them to decode with valid/ready.
// Optional build macro FETCH_BYPASS_EN: forwards a response straight to the
// decode outputs when the buffer is empty and decode is ready.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int                ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0,
  parameter int                FIFO_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               fetch_en,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [ADDR_W-1:0]  imem_req_addr,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  output logic               dec_valid,
  input  logic               dec_ready,
  output logic [INSTR_W-1:0] dec_instr,
  output logic [5:0]         dec_opcode,
  output logic [ADDR_W-1:0]  dec_pc,
  output logic [ADDR_W-1:0]  dec_pc_plus4,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc
);

  localparam int                CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_W-1:0] STEP  = ADDR_W'(PC_STEP);

  fetch_state_e       state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [ADDR_W-1:0]  lat_pc_q, lat_pc_d;
  logic               run_q;
  logic               req_valid, rsp_take, push, pop, bypass;
  logic               dec_valid_q, dec_valid_d;
  logic [INSTR_W-1:0] dec_instr_q, dec_instr_d;
  logic [ADDR_W-1:0]  dec_pc_q, dec_pc_d, dec_pc4_q, dec_pc4_d;
  logic [CNT_W-1:0]   fifo_count;
  fetch_entry_t       push_entry, fifo_head, fifo_next, head_sel;
  logic               unused_redirect_lsb;

  assign unused_redirect_lsb = ^redirect_pc[1:0];

  // Fetch FSM: request issue, response acceptance and stale-response drop
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    lat_pc_d  = lat_pc_q;
    req_valid = 1'b0;
    rsp_take  = 1'b0;
    unique case (state_q)
      F_REQ: begin
        // Issue only with a free buffer slot so the response always has room
        req_valid = run_q && fetch_en && !redirect_valid &&
                    (fifo_count < CNT_W'(FIFO_DEPTH));
        if (req_valid && imem_req_ready) begin
          lat_pc_d = pc_q;
          pc_d     = pc_q + STEP;
          state_d  = F_WAIT;
        end
      end
      F_WAIT: begin
        if (imem_rsp_valid) begin
          rsp_take = !redirect_valid;
          state_d  = F_REQ;
        end else if (redirect_valid) begin
          state_d = F_DROP;
        end
      end
      F_DROP: begin
        if (imem_rsp_valid) state_d = F_REQ;
      end
      default: state_d = F_REQ;
    endcase
    if (redirect_valid) pc_d = {redirect_pc[ADDR_W-1:2], 2'b00};
  end

`ifdef FETCH_BYPASS_EN
  assign bypass = rsp_take && (fifo_count == '0) && dec_ready;
`else
  assign bypass = 1'b0;
`endif

  assign push             = rsp_take && !bypass;
  assign pop              = dec_ready && (fifo_count != '0) && !redirect_valid;
  assign push_entry.instr = imem_rsp_data;
  assign push_entry.pc    = MAX_ADDR_W'(lat_pc_q);

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (redirect_valid),
    .wdata_i (push_entry),
    .head_o  (fifo_head),
    .next_o  (fifo_next),
    .count_o (fifo_count)
  );

  // Predict the buffer head after this edge so decode sees it one cycle after it lands
  always_comb begin
    dec_valid_d = 1'b0;
    dec_instr_d = dec_instr_q;
    dec_pc_d    = dec_pc_q;
    dec_pc4_d   = dec_pc4_q;
    head_sel    = push_entry;
    if (pop) begin
      if (fifo_count > CNT_W'(1)) head_sel = fifo_next;
    end else if (fifo_count != '0) begin
      head_sel = fifo_head;
    end
    if (!redirect_valid) begin
      dec_valid_d = (pop ? (fifo_count > CNT_W'(1)) : (fifo_count != '0)) || push;
      if (dec_valid_d) begin
        dec_instr_d = head_sel.instr;
        dec_pc_d    = ADDR_W'(head_sel.pc);
        dec_pc4_d   = ADDR_W'(head_sel.pc) + STEP;
      end
    end
  end

  // State, PC and decode-output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= F_REQ;
      pc_q        <= RESET_PC;
      lat_pc_q    <= '0;
      run_q       <= 1'b0;
      dec_valid_q <= 1'b0;
      dec_instr_q <= '0;
      dec_pc_q    <= '0;
      dec_pc4_q   <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      lat_pc_q    <= lat_pc_d;
      run_q       <= 1'b1;
      dec_valid_q <= dec_valid_d;
      dec_instr_q <= dec_instr_d;
      dec_pc_q    <= dec_pc_d;
      dec_pc4_q   <= dec_pc4_d;
    end
  end

  assign imem_req_valid = req_valid;
  assign imem_req_addr  = pc_q;

`ifdef FETCH_BYPASS_EN
  assign dec_valid    = dec_valid_q || bypass;
  assign dec_instr    = bypass ? imem_rsp_data   : dec_instr_q;
  assign dec_pc       = bypass ? lat_pc_q        : dec_pc_q;
  assign dec_pc_plus4 = bypass ? lat_pc_q + STEP : dec_pc4_q;
`else
  assign dec_valid    = dec_valid_q;
  assign dec_instr    = dec_instr_q;
  assign dec_pc       = dec_pc_q;
  assign dec_pc_plus4 = dec_pc4_q;
`endif

  assign dec_opcode = dec_instr[OPC_MSB:OPC_LSB];

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Instruction fetch unit; the producer of the 6-bit opcode consumed by the main control decoder.
- Holds the PC and issues word reads to instruction memory over a valid/ready request port with a variable-latency response.
- Buffers returned instructions in a small FIFO and presents them to the decode stage with a valid/ready handshake.
- Accepts redirects (taken beq, jump) from execute and flushes stale work.

Parameters:
ADDR_W, 32, PC / instruction-memory byte-address width
RESET_PC, 0, PC value loaded on reset
FIFO_DEPTH, 2, decode-side instruction buffer entries (power of 2, ≥2)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
fetch_en  in  1  1 = allow new memory requests; 0 = hold PC, finish in-flight request
imem_req_valid  out  1  read request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  ADDR_W  word-aligned read address (= PC)
imem_rsp_valid  in  1  read data valid (exactly one per accepted request)
imem_rsp_data  in  32  instruction word
dec_valid  out  1  instruction available to decode
dec_ready  in  1  decode consumes instruction
dec_instr  out  32  instruction word
dec_opcode  out  6  dec_instr[31:26], to main control decoder
dec_pc  out  ADDR_W  address of dec_instr
dec_pc_plus4  out  ADDR_W  dec_pc + 4 (branch-target base)
redirect_valid  in  1  execute redirect (taken branch / jump)
redirect_pc  in  ADDR_W  new fetch address

Behaviour:
- Reset (async, rst_n=0): PC=RESET_PC, FSM=F_REQ, FIFO empty, imem_req_valid=0, dec_valid=0, dec_instr=0, dec_pc=0, dec_pc_plus4=0. Outputs stay at these values until the first post-reset edge.
- At most one outstanding memory request.
- FSM states:
  - F_REQ:
    - imem_req_valid = fetch_en & !redirect_valid & (fifo_count < FIFO_DEPTH).
    - On handshake: latch address, PC += 4, go to F_WAIT.
  - F_WAIT:
    - On imem_rsp_valid, push {data, latched addr} into the FIFO, go to F_REQ.
    - A redirect without a response this cycle goes to F_DROP.
    - A redirect with a response in the same cycle discards the response and goes to F_REQ.
  - F_DROP:
    - imem_req_valid=0.
    - The next imem_rsp_valid is discarded, then go to F_REQ.
    - A further redirect in F_DROP updates the PC only.
- Redirect (any state):
  - PC = {redirect_pc[ADDR_W-1:2], 2'b00}.
  - FIFO flushed in the same cycle; dec_valid=0 the next cycle.
  - A pop in the same cycle is ignored; the flush wins.
- FIFO:
  - Simultaneous push and pop permitted at any count, including full.
  - Push is never attempted when full, because issue reserves a slot.
  - dec_* are registered FIFO-head outputs. Latency from response to dec_valid is 1 cycle.
- PC arithmetic is modulo 2^ADDR_W; 0xFFFF_FFFC + 4 = 0x0000_0000 with no flag.
- dec_pc_plus4 wraps the same way.
- fetch_en=0 mid-F_WAIT: the response is still accepted; no new request is issued.
- dec_ready held 0: the FIFO fills and requests stop. No response is lost, because a slot was reserved.
- Request address and PC are stable while imem_req_valid=1 and ready=0. valid is not withdrawn except by redirect or fetch_en=0.

Optional Feature:
Macro FETCH_BYPASS_EN.
- Defined: when the FIFO is empty and dec_ready=1 at response time, the response is forwarded combinationally to dec_* in the same cycle and is not stored. Response-to-decode latency is 0 cycles.
- Defined: a redirect in the same cycle still suppresses the bypass, with dec_valid=0.
- Undefined: all responses go through the FIFO, 1-cycle latency, registered outputs only.

Decomposition:
- Package fetch_pkg holds:
  - INSTR_W=32
  - OPC_MSB=31, OPC_LSB=26
  - PC_STEP=4
  - the FSM state enum {F_REQ, F_WAIT, F_DROP}
  - the FIFO entry struct {instr, pc}
- One sub-module: fetch_fifo. Parameterised depth, push/pop/flush, count output; storage and pointers only.

Test Plan:
1. Reset release, RESET_PC=0, memory 1-cycle latency, dec_ready=1 → requests to 0x0, 0x4, 0x8. dec_pc 0x0 first with dec_opcode=0x23 for word 0x8C010004.
2. dec_ready=0 for 10 cycles, FIFO_DEPTH=2 → exactly 2 entries buffered, imem_req_valid=0 afterward. Release: instructions at 0x0, 0x4, 0x8 delivered in order, none lost.
3. Redirect to 0x40 while in F_WAIT, response 3 cycles later → stale response dropped. Next dec_pc=0x40 and FIFO flushed.
4. redirect_pc=0x43 in the same cycle as imem_rsp_valid → response discarded, next request addr=0x40.
5. PC=0xFFFFFFFC → request at 0xFFFFFFFC then 0x0. dec_pc_plus4=0x0 for the first.
6. fetch_en=0 during F_WAIT → in-flight instruction delivered, no further request until fetch_en=1. With FETCH_BYPASS_EN defined, check dec_valid in the same cycle as imem_rsp_valid when the FIFO is empty.
